lookahead_route_unit: RTL

Registered, per-virtual-channel look-ahead routing unit for one input port of a 2D mesh/torus router. It takes the output port a flit will use at this router and computes the output port it will need at the next router. The choice follows XY or YX dimension-order routing, on a mesh or a torus. Head flits compute and latch a route per VC; body and tail flits reuse the latched route. It sits between the input VC buffer and the crossbar/VC allocator, behind a one-stage valid/ready register.

---
 rtl/noc_route_pkg.sv | 36 +++
 rtl/lk_route_calc.sv | 124 ++++++++++++
 rtl/lookahead_route_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/noc_route_pkg.sv
// Shared NoC routing definitions: output-port codes, routing algorithm and
// topology selectors, and the width helper used to size address fields.
package noc_route_pkg;

    localparam int PORT_W = 3;

    typedef enum logic [PORT_W-1:0] {
        PORT_LOCAL = 3'd0,
        PORT_EAST  = 3'd1,
        PORT_NORTH = 3'd2,
        PORT_WEST  = 3'd3,
        PORT_SOUTH = 3'd4
    } port_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_POS  = 2'd1,
        DIR_NEG  = 2'd2
    } dir_e;

    localparam bit [15:0] ALG_XY     = "XY";
    localparam bit [15:0] ALG_YX     = "YX";
    localparam bit [39:0] TOPO_MESH  = "MESH";
    localparam bit [39:0] TOPO_TORUS = "TORUS";

    // Ceiling log2, floored at 1 so single-entry fields still get a real bit.
    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lk_route_calc.sv
// Combinational look-ahead route: from the port a flit leaves this router by,
// derive the next router's coordinates and the port it will take there.
module lk_route_calc
    import noc_route_pkg::*;
#(
    parameter int        X_NODE_NUM = 4,
    parameter int        Y_NODE_NUM = 4,
    parameter int        SW_X_ADDR  = 2,
    parameter int        SW_Y_ADDR  = 1,
    parameter bit [15:0] ROUTE_ALG  = ALG_XY,
    parameter bit [39:0] TOPOLOGY   = TOPO_MESH,
    localparam int       XW         = log2(X_NODE_NUM),
    localparam int       YW         = log2(Y_NODE_NUM)
) (
    input  logic [PORT_W-1:0] port,
    input  logic [XW-1:0]     dest_x,
    input  logic [YW-1:0]     dest_y,
    output logic [PORT_W-1:0] lk_port,
    output logic              edge_err
);

    localparam bit          IS_TORUS = (TOPOLOGY == TOPO_TORUS);
    localparam bit          IS_YX    = (ROUTE_ALG == ALG_YX);
    localparam logic [XW:0] XN       = (XW+1)'(X_NODE_NUM);
    localparam logic [YW:0] YN       = (YW+1)'(Y_NODE_NUM);
    localparam logic [XW:0] X_ONE    = (XW+1)'(1);
    localparam logic [YW:0] Y_ONE    = (YW+1)'(1);

    logic [XW:0]        next_x;
    logic [YW:0]        next_y;
    logic               illegal;
    logic               off_grid;
    logic signed [XW:0] dx;
    logic signed [YW:0] dy;
    logic [XW:0]        mod_x;
    logic [YW:0]        mod_y;
    dir_e               x_dir;
    dir_e               y_dir;
    port_e              x_port;
    port_e              y_port;

    // One extra bit lets a step off either edge show up as N or as all-ones.
    always_comb begin
        next_x   = (XW+1)'(SW_X_ADDR);
        next_y   = (YW+1)'(SW_Y_ADDR);
        illegal  = 1'b0;
        off_grid = 1'b0;
        case (port)
            PORT_LOCAL: ;
            PORT_EAST:  next_x = next_x + X_ONE;
            PORT_WEST:  next_x = next_x - X_ONE;
            PORT_NORTH: next_y = next_y - Y_ONE;
            PORT_SOUTH: next_y = next_y + Y_ONE;
            default:    illegal = 1'b1;
        endcase
        if (IS_TORUS) begin
            if (next_x == XN) begin
                next_x = '0;
            end else if (next_x == '1) begin
                next_x = XN - X_ONE;
            end
            if (next_y == YN) begin
                next_y = '0;
            end else if (next_y == '1) begin
                next_y = YN - Y_ONE;
            end
        end else begin
            off_grid = (next_x >= XN) || (next_y >= YN);
        end
    end

    // On a torus, 2*d > N means the negative way round is strictly shorter.
    always_comb begin
        dx    = $signed({1'b0, dest_x}) - $signed(next_x);
        dy    = $signed({1'b0, dest_y}) - $signed(next_y);
        mod_x = dx[XW] ? ($unsigned(dx) + XN) : $unsigned(dx);
        mod_y = dy[YW] ? ($unsigned(dy) + YN) : $unsigned(dy);
        x_dir = DIR_NONE;
        y_dir = DIR_NONE;
        if (IS_TORUS) begin
            if (mod_x != '0) begin
                x_dir = ({mod_x, 1'b0} > {1'b0, XN}) ? DIR_NEG : DIR_POS;
            end
            if (mod_y != '0) begin
                y_dir = ({mod_y, 1'b0} > {1'b0, YN}) ? DIR_NEG : DIR_POS;
            end
        end else begin
            if (dx[XW]) begin
                x_dir = DIR_NEG;
            end else if (dx != '0) begin
                x_dir = DIR_POS;
            end
            if (dy[YW]) begin
                y_dir = DIR_NEG;
            end else if (dy != '0) begin
                y_dir = DIR_POS;
            end
        end
    end

    assign x_port = (x_dir == DIR_POS) ? PORT_EAST  : PORT_WEST;
    assign y_port = (y_dir == DIR_POS) ? PORT_SOUTH : PORT_NORTH;

    always_comb begin
        edge_err = illegal || off_grid;
        lk_port  = PORT_LOCAL;
        if (!edge_err && (port != PORT_LOCAL)) begin
            if (IS_YX) begin
                if (y_dir != DIR_NONE) begin
                    lk_port = y_port;
                end else if (x_dir != DIR_NONE) begin
                    lk_port = x_port;
                end
            end else begin
                if (x_dir != DIR_NONE) begin
                    lk_port = x_port;
                end else if (y_dir != DIR_NONE) begin
                    lk_port = y_port;
                end
            end
        end
    end

endmodule

// File: rtl/lookahead_route_unit.sv
// Per-VC look-ahead routing stage: heads compute and latch a next-hop port,
// bodies and tails replay it, all behind a single valid/ready register.
module lookahead_route_unit
    import noc_route_pkg::*;
#(
    parameter int        V          = 4,
    parameter int        X_NODE_NUM = 4,
    parameter int        Y_NODE_NUM = 4,
    parameter int        SW_X_ADDR  = 2,
    parameter int        SW_Y_ADDR  = 1,
    parameter bit [15:0] ROUTE_ALG  = ALG_XY,
    parameter bit [39:0] TOPOLOGY   = TOPO_MESH,
    localparam int       VW         = log2(V),
    localparam int       XW         = log2(X_NODE_NUM),
    localparam int       YW         = log2(Y_NODE_NUM)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_head,
    input  logic              in_tail,
    input  logic [VW-1:0]     in_vc,
    input  logic [XW-1:0]     in_dest_x,
    input  logic [YW-1:0]     in_dest_y,
    input  logic [PORT_W-1:0] in_port,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [VW-1:0]     out_vc,
    output logic              out_head,
    output logic              out_tail,
    output logic [PORT_W-1:0] out_lk_port,
    output logic              route_err,
    input  logic              err_clr
);

    logic              accept;
    logic [PORT_W-1:0] calc_lk;
    logic              calc_err;
    logic              vc_ok;
    logic              sel_busy;
    logic [PORT_W-1:0] sel_route;
    logic [PORT_W-1:0] next_lk;
    logic              next_err;

    logic [V-1:0]      vc_busy;
    logic [PORT_W-1:0] route_reg [V];

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    lk_route_calc #(
        .X_NODE_NUM (X_NODE_NUM),
        .Y_NODE_NUM (Y_NODE_NUM),
        .SW_X_ADDR  (SW_X_ADDR),
        .SW_Y_ADDR  (SW_Y_ADDR),
        .ROUTE_ALG  (ROUTE_ALG),
        .TOPOLOGY   (TOPOLOGY)
    ) u_calc (
        .port     (in_port),
        .dest_x   (in_dest_x),
        .dest_y   (in_dest_y),
        .lk_port  (calc_lk),
        .edge_err (calc_err)
    );

    // A VC index beyond V (non power-of-two V) is treated as a protocol error.
    always_comb begin
        vc_ok     = (int'(in_vc) < V);
        sel_busy  = vc_ok && vc_busy[in_vc];
        sel_route = vc_ok ? route_reg[in_vc] : PORT_LOCAL;
        next_lk   = PORT_LOCAL;
        next_err  = 1'b0;
        if (!vc_ok) begin
            next_err = 1'b1;
        end else if (in_head) begin
            next_lk  = calc_lk;
            next_err = calc_err || sel_busy;
        end else if (sel_busy) begin
            next_lk  = sel_route;
        end else begin
            next_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_vc      <= '0;
            out_head    <= 1'b0;
            out_tail    <= 1'b0;
            out_lk_port <= PORT_LOCAL;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_vc      <= in_vc;
                out_head    <= in_head;
                out_tail    <= in_tail;
                out_lk_port <= next_lk;
            end
        end
    end

    // A head always rewrites the route, even over a busy VC, so the newest
    // packet's bodies follow the newest route.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vc_busy <= '0;
            for (int i = 0; i < V; i++) begin
                route_reg[i] <= PORT_LOCAL;
            end
        end else if (accept && vc_ok) begin
            if (in_head) begin
                route_reg[in_vc] <= calc_lk;
                vc_busy[in_vc]   <= !in_tail;
            end else if (in_tail) begin
                vc_busy[in_vc]   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            route_err <= 1'b0;
        end else if (accept && next_err) begin
            route_err <= 1'b1;
        end else if (err_clr) begin
            route_err <= 1'b0;
        end
    end

endmodule
